// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing the single-port instruction RAM between fetch and loader.
// Define IMEM_ARB_STATS_EN to add saturating per-port grant counters.
module imem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512,
  parameter int IDX_WIDTH  = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  input  logic                  if_flush,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_instr,
  output logic                  if_rsp_err,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  input  logic                  ld_req_we,
  input  logic [ADDR_WIDTH-1:0] ld_req_addr,
  input  logic [DATA_WIDTH-1:0] ld_req_wdata,
  output logic                  ld_rsp_valid,
  output logic [DATA_WIDTH-1:0] ld_rsp_rdata,
  output logic                  ld_rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [IDX_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]           if_grant_cnt,
  output logic [15:0]           ld_grant_cnt
`endif
);

  typedef enum logic {PORT_IF = 1'b0, PORT_LD = 1'b1} port_e;

  localparam logic [ADDR_WIDTH-3:0] IDX_LIMIT = (ADDR_WIDTH-2)'(MEM_SIZE);

  port_e last_grant;
  port_e pend_owner;
  logic  pend_valid;
  logic  pend_err;
  logic  pend_we;
  logic  grant_if;
  logic  grant_ld;
  logic  if_err;
  logic  ld_err;
  logic  pend_if;
  logic  pend_ld;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_WIDTH-1:2] >= IDX_LIMIT);
  endfunction

  assign if_err = addr_err(if_req_addr);
  assign ld_err = addr_err(ld_req_addr);

  // Gating with rst_n keeps every output quiet while reset is held.
  always_comb begin
    grant_if = 1'b0;
    grant_ld = 1'b0;
    if (rst_n) begin
      if (if_req_valid && (!ld_req_valid || last_grant == PORT_LD)) begin
        grant_if = 1'b1;
      end else if (ld_req_valid) begin
        grant_ld = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign ld_req_ready = grant_ld;

  // Errored requests consume the grant slot but never touch the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_if && !if_err) begin
      mem_en   = 1'b1;
      mem_addr = if_req_addr[IDX_WIDTH+1:2];
    end else if (grant_ld && !ld_err) begin
      mem_en   = 1'b1;
      mem_we   = ld_req_we;
      mem_addr = ld_req_addr[IDX_WIDTH+1:2];
      if (ld_req_we) begin
        mem_wdata = ld_req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_owner <= PORT_IF;
      pend_err   <= 1'b0;
      pend_we    <= 1'b0;
      last_grant <= PORT_LD;
    end else begin
      pend_valid <= grant_if | grant_ld;
      if (grant_if) begin
        pend_owner <= PORT_IF;
        pend_err   <= if_err;
        pend_we    <= 1'b0;
        last_grant <= PORT_IF;
      end else if (grant_ld) begin
        pend_owner <= PORT_LD;
        pend_err   <= ld_err;
        pend_we    <= ld_req_we;
        last_grant <= PORT_LD;
      end
    end
  end

  assign pend_if = pend_valid && (pend_owner == PORT_IF);
  assign pend_ld = pend_valid && (pend_owner == PORT_LD);

  assign if_rsp_valid = pend_if & ~if_flush;
  assign if_rsp_err   = if_rsp_valid & pend_err;
  assign if_rsp_instr = (if_rsp_valid && !pend_err) ? mem_rdata : '0;

  assign ld_rsp_valid = pend_ld;
  assign ld_rsp_err   = pend_ld & pend_err;
  assign ld_rsp_rdata = (pend_ld && !pend_err && !pend_we) ? mem_rdata : '0;

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_grant_cnt <= '0;
      ld_grant_cnt <= '0;
    end else begin
      if (grant_if && if_grant_cnt != 16'hFFFF) begin
        if_grant_cnt <= if_grant_cnt + 16'd1;
      end
      if (grant_ld && ld_grant_cnt != 16'hFFFF) begin
        ld_grant_cnt <= ld_grant_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Table-driven bench for imem_port_arbiter with a response scoreboard and a RAM model.
// Builds with or without IMEM_ARB_STATS_EN.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_instr;
  logic        if_rsp_err;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic        ld_req_we;
  logic [31:0] ld_req_addr;
  logic [31:0] ld_req_wdata;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_rdata;
  logic        ld_rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] if_grant_cnt;
  logic [15:0] ld_grant_cnt;
`endif

  imem_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_flush     (if_flush),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_instr (if_rsp_instr),
    .if_rsp_err   (if_rsp_err),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_req_we    (ld_req_we),
    .ld_req_addr  (ld_req_addr),
    .ld_req_wdata (ld_req_wdata),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_rdata (ld_rsp_rdata),
    .ld_rsp_err   (ld_rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    ,
    .if_grant_cnt (if_grant_cnt),
    .ld_grant_cnt (ld_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM macro stand-in.
  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        if_v;
    logic [31:0] if_a;
    logic        flush;
    logic        ld_v;
    logic        ld_we;
    logic [31:0] ld_a;
    logic [31:0] ld_wd;
    logic        exp_if_gnt;
    logic        exp_ld_gnt;
    logic        exp_en;
    logic        exp_we;
  } vec_t;

  typedef struct {
    int          due;
    logic        is_if;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  vec_t        vecs[$];
  rsp_t        sb[$];
  logic [31:0] ref_mem [0:511];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          exp_if_cnt = 0;
  int          exp_ld_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic add_vec(input logic if_v, input logic [31:0] if_a, input logic flush,
                         input logic ld_v, input logic ld_we, input logic [31:0] ld_a,
                         input logic [31:0] ld_wd, input logic e_if, input logic e_ld,
                         input logic e_en, input logic e_we);
    vec_t v;
    v.if_v = if_v; v.if_a = if_a; v.flush = flush;
    v.ld_v = ld_v; v.ld_we = ld_we; v.ld_a = ld_a; v.ld_wd = ld_wd;
    v.exp_if_gnt = e_if; v.exp_ld_gnt = e_ld; v.exp_en = e_en; v.exp_we = e_we;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req_valid = v.if_v;
    if_req_addr  = v.if_a;
    if_flush     = v.flush;
    ld_req_valid = v.ld_v;
    ld_req_we    = v.ld_we;
    ld_req_addr  = v.ld_a;
    ld_req_wdata = v.ld_wd;
  endtask

  task automatic checkOutput(input vec_t v);
    rsp_t        r;
    logic        e_iv, e_ie, e_lv, e_le, acc_if, err;
    logic [31:0] e_id, e_ld, a, data;
    logic [8:0]  idx;
    e_iv = 0; e_ie = 0; e_id = 0; e_lv = 0; e_le = 0; e_ld = 0;
    if (sb.size() > 0 && sb[0].due == cycle) begin
      r = sb.pop_front();
      if (r.is_if) begin
        e_iv = !v.flush;
        e_ie = e_iv & r.err;
        e_id = e_iv ? r.data : 32'h0;
      end else begin
        e_lv = 1'b1;
        e_le = r.err;
        e_ld = r.data;
      end
    end
    chk("if_req_ready", 32'(if_req_ready), 32'(v.exp_if_gnt));
    chk("ld_req_ready", 32'(ld_req_ready), 32'(v.exp_ld_gnt));
    chk("mem_en", 32'(mem_en), 32'(v.exp_en));
    chk("mem_we", 32'(mem_we), 32'(v.exp_we));
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(e_iv));
    chk("if_rsp_err", 32'(if_rsp_err), 32'(e_ie));
    chk("if_rsp_instr", if_rsp_instr, e_id);
    chk("ld_rsp_valid", 32'(ld_rsp_valid), 32'(e_lv));
    chk("ld_rsp_err", 32'(ld_rsp_err), 32'(e_le));
    chk("ld_rsp_rdata", ld_rsp_rdata, e_ld);
    if (v.exp_if_gnt || v.exp_ld_gnt) begin
      acc_if = v.exp_if_gnt;
      a      = acc_if ? v.if_a : v.ld_a;
      err    = (a[1:0] != 2'b00) || (a >= 32'h0000_0800);
      idx    = a[10:2];
      data   = (err || (!acc_if && v.ld_we)) ? 32'h0 : ref_mem[idx];
      if (v.exp_en) chk("mem_addr", 32'(mem_addr), 32'(idx));
      if (v.exp_we) chk("mem_wdata", mem_wdata, v.ld_wd);
      if (!err && !acc_if && v.ld_we) ref_mem[idx] = v.ld_wd;
      sb.push_back('{due: cycle + 1, is_if: acc_if, err: err, data: data});
      if (acc_if) exp_if_cnt++;
      else        exp_ld_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]     = 32'hA500_0000 ^ (i * 32'h0001_0101);
      ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
    end
    ram[2]     = 32'h0050_0093;
    ref_mem[2] = 32'h0050_0093;

    //       if_v addr          fl  ld_v we  ld_addr       wdata         gIF gLD en  we
    add_vec(1, 32'h0000_0008, 0, 1, 0, 32'h0000_0004, 32'h0,         1, 0, 1, 0);
    add_vec(1, 32'h0000_0000, 0, 1, 0, 32'h0000_0004, 32'h0,         0, 1, 1, 0);
    add_vec(1, 32'h0000_0000, 0, 1, 0, 32'h0000_000C, 32'h0,         1, 0, 1, 0);
    add_vec(1, 32'h0000_0014, 0, 1, 0, 32'h0000_000C, 32'h0,         0, 1, 1, 0);
    add_vec(0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    add_vec(1, 32'h0000_0008, 0, 0, 0, 32'h0,         32'h0,         1, 0, 1, 0);
    add_vec(0, 32'h0,         0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 1, 1);
    add_vec(1, 32'h0000_0010, 0, 0, 0, 32'h0,         32'h0,         1, 0, 1, 0);
    add_vec(1, 32'h0000_0802, 0, 1, 1, 32'h0000_0800, 32'h0000_0001, 0, 1, 0, 0);
    add_vec(1, 32'h0000_0802, 0, 0, 0, 32'h0,         32'h0,         1, 0, 0, 0);
    add_vec(1, 32'h0000_07FC, 0, 0, 0, 32'h0,         32'h0,         1, 0, 1, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0000_07FE, 32'h0,         0, 1, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0000_07FC, 32'h0,         0, 1, 1, 0);
    add_vec(1, 32'h0000_0020, 0, 0, 0, 32'h0,         32'h0,         1, 0, 1, 0);
    add_vec(1, 32'h0000_0024, 1, 0, 0, 32'h0,         32'h0,         1, 0, 1, 0);
    add_vec(0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h1000_0000, 32'h0,         0, 1, 0, 0);
    add_vec(0, 32'h0,         1, 1, 0, 32'h0000_0010, 32'h0,         0, 1, 1, 0);
    add_vec(0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0000_0000, 32'h0,         0, 1, 1, 0);
    add_vec(0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    add_vec(1, 32'h0000_0028, 0, 1, 0, 32'h0000_0008, 32'h0,         1, 0, 1, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0000_0008, 32'h0,         0, 1, 1, 0);
    add_vec(1, 32'h0000_0030, 0, 1, 0, 32'h0000_0004, 32'h0,         1, 0, 1, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0000_0004, 32'h0,         0, 1, 1, 0);
    add_vec(0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0);

    rst_n = 1'b0;
    applyStimulus(vecs[vecs.size() - 1]);
    #2;
    chk("reset if_rsp_valid", 32'(if_rsp_valid), 32'h0);
    chk("reset ld_rsp_valid", 32'(ld_rsp_valid), 32'h0);
    chk("reset mem_en", 32'(mem_en), 32'h0);
    chk("reset if_req_ready", 32'(if_req_ready), 32'h0);
`ifdef IMEM_ARB_STATS_EN
    chk("reset if_grant_cnt", 32'(if_grant_cnt), 32'h0);
    chk("reset ld_grant_cnt", 32'(ld_grant_cnt), 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle = 0;

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i]);
      @(posedge clk); #1;
      cycle++;
    end
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
`ifdef IMEM_ARB_STATS_EN
    chk("if_grant_cnt", 32'(if_grant_cnt), 32'(exp_if_cnt));
    chk("ld_grant_cnt", 32'(ld_grant_cnt), 32'(exp_ld_cnt));
`endif

    // Reset in the cycle after an accepted fetch loses its response.
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0008; if_flush = 1'b0;
    ld_req_valid = 1'b0; ld_req_we = 1'b0; ld_req_addr = 32'h0; ld_req_wdata = 32'h0;
    @(negedge clk);
    chk("pre-reset if_req_ready", 32'(if_req_ready), 32'h1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid-reset if_rsp_valid", 32'(if_rsp_valid), 32'h0);
`ifdef IMEM_ARB_STATS_EN
    chk("mid-reset if_grant_cnt", 32'(if_grant_cnt), 32'h0);
    chk("mid-reset ld_grant_cnt", 32'(ld_grant_cnt), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post-reset if_rsp_valid", 32'(if_rsp_valid), 32'h0);
      chk("post-reset ld_rsp_valid", 32'(ld_rsp_valid), 32'h0);
    end

    // Fresh reset must hand the first tie to fetch.
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0004;
    ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0004;
    #1;
    chk("post-reset tie if_req_ready", 32'(if_req_ready), 32'h1);
    chk("post-reset tie ld_req_ready", 32'(ld_req_ready), 32'h0);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("post-reset tie ld_req_ready next", 32'(ld_req_ready), 32'h1);
    chk("post-reset fetch rsp", if_rsp_instr, ref_mem[1]);
    @(posedge clk); #1;
    ld_req_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
